// File: rtl/paddsb_serial.sv
// rtl/paddsb_serial.sv - nibble-serial PADDSB saturating add/subtract, one lane per cycle
module paddsb_serial #(
  parameter int LANES = 4,
  parameter int LW    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LANES*LW-1:0]   A,
  input  logic [LANES*LW-1:0]   B,
  input  logic                  sub,
  output logic                  busy,
  output logic                  done,
  output logic [LANES*LW-1:0]   Sum,
  output logic [LANES-1:0]      sat
);

  localparam int W  = LANES * LW;
  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

  // Saturation bounds in the sign-extended (LW+1)-bit domain: +7 and -8 for LW=4.
  localparam logic signed [LW:0] MAX_V = {2'b00, {(LW-1){1'b1}}};
  localparam logic signed [LW:0] MIN_V = {2'b11, {(LW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic              last_lane;

  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic              sub_q;
  logic [IW-1:0]     idx;

  logic [LW-1:0]     a_lane;
  logic [LW-1:0]     b_lane;
  logic signed [LW:0] a_ext;
  logic signed [LW:0] b_ext;
  logic signed [LW:0] r_ext;
  logic [LW-1:0]     lane_res;
  logic              lane_sat;

  assign last_lane = (idx == IW'(LANES - 1));

  // Status outputs are pure decodes of the registered state.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a start is only honoured when not computing lanes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_lane) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Single shared lane datapath: sign-extend, add or subtract, then clamp.
  always_comb begin
    a_lane   = a_q[idx*LW +: LW];
    b_lane   = b_q[idx*LW +: LW];
    a_ext    = $signed({a_lane[LW-1], a_lane});
    b_ext    = $signed({b_lane[LW-1], b_lane});
    // One extra bit holds every sum/difference of two LW-bit values exactly.
    r_ext    = sub_q ? (a_ext - b_ext) : (a_ext + b_ext);
    lane_res = r_ext[LW-1:0];
    lane_sat = 1'b0;
    if (r_ext > MAX_V) begin
      lane_res = MAX_V[LW-1:0];
      lane_sat = 1'b1;
    end else if (r_ext < MIN_V) begin
      lane_res = MIN_V[LW-1:0];
      lane_sat = 1'b1;
    end
  end

  // Operand capture on accept, then one lane written per RUN cycle, LSB lane first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sub_q <= 1'b0;
      idx   <= '0;
      Sum   <= '0;
      sat   <= '0;
    end else if (accept) begin
      a_q   <= A;
      b_q   <= B;
      sub_q <= sub;
      idx   <= '0;
      Sum   <= '0;
      sat   <= '0;
    end else if (state == RUN) begin
      Sum[idx*LW +: LW] <= lane_res;
      sat[idx]          <= lane_sat;
      idx               <= last_lane ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_paddsb_serial.sv
// tb/tb_paddsb_serial.sv - scoreboard bench for paddsb_serial with a lane-arithmetic reference model
module tb_paddsb_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] A = 16'h0;
  logic [15:0] B = 16'h0;
  logic        busy;
  logic        done;
  logic [15:0] Sum;
  logic [3:0]  sat;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  logic [19:0] exp_q[$];
  logic [19:0] mon_e;

  always #5 clk = ~clk;

  paddsb_serial #(.LANES(4), .LW(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .sub  (sub),
    .busy (busy),
    .done (done),
    .Sum  (Sum),
    .sat  (sat)
  );

  // Reference: each nibble as a signed integer, exact arithmetic, clamp to [-8, 7].
  function automatic logic [19:0] ref_model(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [15:0] rs;
    logic [3:0]  st;
    logic [3:0]  na;
    logic [3:0]  nb;
    int x;
    int y;
    int r;
    rs = 16'h0;
    st = 4'h0;
    for (int i = 0; i < 4; i++) begin
      na = a[4*i +: 4];
      nb = b[4*i +: 4];
      x = (na >= 4'd8) ? int'(na) - 16 : int'(na);
      y = (nb >= 4'd8) ? int'(nb) - 16 : int'(nb);
      r = s ? (x - y) : (x + y);
      if (r > 7) begin
        rs[4*i +: 4] = 4'h7;
        st[i] = 1'b1;
      end else if (r < -8) begin
        rs[4*i +: 4] = 4'h8;
        st[i] = 1'b1;
      end else begin
        rs[4*i +: 4] = 4'(r);
      end
    end
    return {st, rs};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse pops one expected result from the scoreboard.
  always @(negedge clk) begin
    if (!rst && done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_sum", {16'h0, Sum}, {16'h0, mon_e[15:0]});
        check("result_sat", {28'h0, sat}, {28'h0, mon_e[19:16]});
      end
    end
  end

  // Entered at a negedge; returns at the negedge where done is visible, so a
  // following call with no gap lands start in the DONE cycle (back-to-back).
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s, input bit hold);
    logic [19:0] e;
    logic [15:0] m;
    logic [3:0]  ms;
    e = ref_model(a, b, s);
    exp_q.push_back(e);
    A = a;
    B = b;
    sub = s;
    start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (hold && k <= 4) begin
        A = 16'($urandom);
        B = 16'($urandom);
        sub = 1'($urandom);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      check("busy", {31'h0, busy}, (k <= 4) ? 32'd1 : 32'd0);
      check("done", {31'h0, done}, (k == 5) ? 32'd1 : 32'd0);
      m  = 16'((32'h1 << (4 * (k - 1))) - 1);
      ms = 4'((32'h1 << (k - 1)) - 1);
      check("sum_progress", {16'h0, Sum}, {16'h0, e[15:0] & m});
      check("sat_progress", {28'h0, sat}, {28'h0, e[19:16] & ms});
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_before;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_sum",  {16'h0, Sum},  32'd0);
    check("reset_sat",  {28'h0, sat},  32'd0);
    check("reset_busy", {31'h0, busy}, 32'd0);
    check("reset_done", {31'h0, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(16'h1234, 16'h1111, 1'b0, 1'b0); @(negedge clk);
    run_op(16'h7777, 16'h1111, 1'b0, 1'b0); @(negedge clk);
    run_op(16'h8888, 16'h8888, 1'b0, 1'b0); @(negedge clk);
    run_op(16'h4444, 16'h1111, 1'b1, 1'b0); @(negedge clk);
    run_op(16'h7777, 16'h8888, 1'b1, 1'b0); @(negedge clk);
    run_op(16'h8888, 16'h7777, 1'b1, 1'b0); @(negedge clk);
    run_op(16'h0000, 16'h8888, 1'b1, 1'b0); @(negedge clk);
    run_op(16'h7F80, 16'h1181, 1'b0, 1'b0); @(negedge clk);
    run_op(16'h1234, 16'h1111, 1'b0, 1'b1); @(negedge clk);
    run_op(16'h4444, 16'h1111, 1'b1, 1'b0);
    run_op(16'h7F80, 16'h1181, 1'b0, 1'b0);
    @(negedge clk);

    // Reset in the second RUN cycle: lane 0 already written, must be wiped.
    A = 16'h1234;
    B = 16'h1111;
    sub = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_reset_lane0", {28'h0, Sum[3:0]}, 32'h5);
    done_before = n_done;
    rst = 1'b1;
    #1;
    check("midrst_sum",  {16'h0, Sum},  32'd0);
    check("midrst_sat",  {28'h0, sat},  32'd0);
    check("midrst_busy", {31'h0, busy}, 32'd0);
    check("midrst_done", {31'h0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_done_after_reset", {31'h0, done}, 32'd0);
      check("idle_after_reset", {31'h0, busy}, 32'd0);
    end
    check("dropped_op_count", n_done, done_before);

    for (int n = 0; n < 150; n++) begin
      int gap;
      run_op(16'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/paddsb_serial.md
Name: paddsb_serial

Overview:
- Multi-cycle, nibble-serial implementation of the PADDSB parallel saturating add/subtract.
- Sits behind the execute stage as the low-area option for the PADDSB path.
- Computes one 4-bit lane per cycle, least-significant nibble first.
- Operands are accepted with a start/busy/done handshake; the result is returned with a per-lane saturation flag vector.

Parameters:
- LANES, 4, number of 4-bit lanes in the operand; the datapath is LANES*4 bits wide.
- LW, 4, lane width in bits; fixed at 4, any other value is illegal.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- A  input  16  operand A; sampled on the accepted start.
- B  input  16  operand B; sampled on the accepted start.
- sub  input  1  0 = A+B, 1 = A-B; sampled on the accepted start.
- busy  output  1  high while lanes are being computed (state RUN).
- done  output  1  one-cycle pulse; Sum and sat are valid and stable.
- Sum  output  16  saturated per-lane result.
- sat  output  4  sat[i] = 1 if lane i saturated.

Behaviour:
- States: IDLE, RUN, DONE. Lane index idx is a 2-bit counter.
- Reset (async, any state, including mid-operation): state=IDLE, idx=0, Sum=0, sat=0, busy=0, done=0, operand registers=0. The in-flight operation is dropped and never reports done.
- IDLE: start=1 at edge k → latch A, B, sub; clear Sum and sat to 0; idx=0; go to RUN. start=0 → stay in IDLE.
- RUN: at each edge, compute lane idx, write Sum[4*idx+3:4*idx] and sat[idx], then idx++.
  - After lane 3 is written (edge k+4) → go to DONE; idx wraps to 0.
  - start is ignored in RUN; the operand registers do not change.
- DONE: done=1 for exactly one cycle.
  - start=1 → accepted exactly as in IDLE, back-to-back; go to RUN.
  - start=0 → go to IDLE.
- Timing: start sampled at edge k gives busy high for cycles k+1..k+4 and done high for cycle k+5 (after edge k+4). Latency is 4 cycles to the last lane, 5 to the done pulse.
- Sum and sat hold their values after DONE until the next accepted start clears them.
- busy = (state==RUN). done = (state==DONE). Both are registered-state decodes with no combinational path from the inputs.
- Lane arithmetic, with a = A lane and b = B lane, each sign-extended to 5 bits:
  - r = sub ? a-b : a+b, in 5-bit signed, range -16..+15.
  - r > 7 → lane result 4'h7, sat=1.
  - r < -8 → lane result 4'h8, sat=1.
  - Otherwise lane result = r[3:0], sat=0.
- Boundary cases:
  - sub with b=4'h8: -b=+8 is representable in 5 bits, so 0-8 saturates to 7.
  - Lanes are fully independent; no carry crosses lanes.

Test Plan:
- Add, no saturation: sub=0, A=1234, B=1111, start pulse → done at k+5, Sum=2345, sat=0000; busy high for exactly 4 cycles.
- Add, saturate both ways: A=7777, B=1111 → Sum=7777, sat=1111. A=8888, B=8888 → Sum=8888, sat=1111.
- Subtract:
  - A=4444, B=1111 → Sum=3333, sat=0000.
  - A=7777, B=8888 → Sum=7777, sat=1111.
  - A=8888, B=7777 → Sum=8888, sat=1111.
  - A=0000, B=8888 → Sum=7777, sat=1111.
- Mixed lanes: sub=0, A=7F80, B=1181 → Sum=7081, sat=1010. Also check that Sum[3:0] updates first, one lane per cycle.
- Handshake:
  - start held high through RUN with changed A/B → the result reflects only the first operands.
  - start high in the DONE cycle → second op accepted back-to-back, done pulses again 5 cycles later.
- Reset mid-operation: assert rst during the 2nd RUN cycle → Sum, sat, busy and done go to 0 immediately. After release, no done pulse occurs until a new start.
